// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding, counter sizing and default chunk width for the serializer and UART path
package serializer_pkg;
  localparam int DEFAULT_CHUNK = 8;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  function automatic int cnt_width(input int width, input int chunk);
    return $clog2(width / chunk + 1);
  endfunction
endpackage

// File: rtl/chunk_counter_async.sv
// chunk_counter_async: loadable down-counter with is_one flag; ports clk, reset (async high), load, load_value, dec, cnt, is_one
module chunk_counter_async #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_one
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_value;
    else if (dec) cnt <= cnt - W'(1);
  assign is_one = cnt == W'(1);
endmodule

// File: rtl/register_shift_serializer_async.sv
// register_shift_serializer_async: loads a WIDTH-bit word by valid/ready and emits it as CHUNK-bit chunks by valid/ready
// ports: clk, reset (async high), enable (freeze), load_valid/load_ready/load_data, out_valid/out_ready/out_data, busy, q
// define SERIALIZER_LAST_EN to add out_last, high on the final chunk of each word
module register_shift_serializer_async
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = DEFAULT_CHUNK,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             busy,
  output logic [WIDTH-1:0] q
`ifdef SERIALIZER_LAST_EN
  ,
  output logic             out_last
`endif
);
  localparam int CW = cnt_width(WIDTH, CHUNK);
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end
  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             is_one, load_fire, out_fire;
  assign load_ready = enable & (state == S_IDLE | (is_one & out_ready));
  assign out_valid  = enable & (state == S_SHIFT);
  assign load_fire  = load_valid & load_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_data   = MSB_FIRST ? sr[WIDTH-1 -: CHUNK] : sr[CHUNK-1:0];
  assign busy       = state == S_SHIFT;
  assign q          = sr;
`ifdef SERIALIZER_LAST_EN
  assign out_last   = out_valid & is_one;
`endif
  // load wins over decrement so a back-to-back reload restarts the count
  chunk_counter_async #(.W(CW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (load_fire),
    .load_value(CW'(WIDTH / CHUNK)),
    .dec       (out_fire & ~load_fire),
    .cnt       (cnt),
    .is_one    (is_one)
  );
  // shifting out the last chunk leaves sr all zero, so no separate clear is needed
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      sr    <= '0;
    end else if (load_fire) begin
      state <= S_SHIFT;
      sr    <= load_data;
    end else if (out_fire) begin
      state <= is_one ? S_IDLE : S_SHIFT;
      sr    <= MSB_FIRST ? sr << CHUNK : sr >> CHUNK;
    end
endmodule
